// File: rtl/bit_serializer_tx.sv
// Transmit packet serializer: SYNC pattern, LSB-first payload with zero-stuffing, then EOP.
// One-byte holding buffer feeds an 8-bit shift register so consecutive bytes stream without gaps.
module bit_serializer_tx #(
  parameter logic [7:0]  SYNC_BYTE  = 8'h80,
  parameter int unsigned STUFF_RUN  = 6,
  parameter int unsigned EOP_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst_L,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  input  logic       tx_last,
  output logic       tx_ready,
  output logic       outb,
  output logic       sending,
  output logic       eop,
  output logic       done,
  output logic       err
);

  localparam int unsigned OW = $clog2(STUFF_RUN + 1);
  localparam int unsigned EW = $clog2(EOP_CYCLES + 1);

  typedef enum logic [2:0] {IDLE, SYNC, DATA, STUFF, EOP} state_t;

  state_t          state, state_n;
  logic [7:0]      hold_data, hold_data_n;
  logic            hold_last, hold_last_n;
  logic            hold_full, hold_full_n;
  logic [7:0]      shreg, shreg_n;
  logic            sh_last, sh_last_n;
  logic [2:0]      bitcnt, bitcnt_n;
  logic [OW-1:0]   ones, ones_n;
  logic [EW-1:0]   eopcnt, eopcnt_n;
  logic            pend_end, pend_end_n;
  logic            underrun, underrun_n;

  logic take, unload, stuff_hit, byte_end, eop_final;

  always_ff @(posedge clk or negedge rst_L) begin
    if (!rst_L) begin
      state     <= IDLE;
      hold_data <= '0;
      hold_last <= 1'b0;
      hold_full <= 1'b0;
      shreg     <= '0;
      sh_last   <= 1'b0;
      bitcnt    <= '0;
      ones      <= '0;
      eopcnt    <= '0;
      pend_end  <= 1'b0;
      underrun  <= 1'b0;
    end else begin
      state     <= state_n;
      hold_data <= hold_data_n;
      hold_last <= hold_last_n;
      hold_full <= hold_full_n;
      shreg     <= shreg_n;
      sh_last   <= sh_last_n;
      bitcnt    <= bitcnt_n;
      ones      <= ones_n;
      eopcnt    <= eopcnt_n;
      pend_end  <= pend_end_n;
      underrun  <= underrun_n;
    end
  end

  always_comb begin
    state_n    = state;
    shreg_n    = shreg;
    sh_last_n  = sh_last;
    bitcnt_n   = bitcnt;
    ones_n     = ones;
    eopcnt_n   = eopcnt;
    pend_end_n = pend_end;
    underrun_n = underrun;
    unload     = 1'b0;

    take      = tx_valid & ~hold_full;
    stuff_hit = (state == DATA) && shreg[0] && (ones == OW'(STUFF_RUN - 1));
    // A byte finishes either on its 8th DATA bit or after a stuff bit that followed it.
    byte_end  = ((state == DATA) && (bitcnt == 3'd7) && !stuff_hit) ||
                ((state == STUFF) && pend_end);
    eop_final = (state == EOP) && (eopcnt == EW'(EOP_CYCLES - 1));

    case (state)
      IDLE: begin
        if (hold_full || take) begin
          state_n  = SYNC;
          bitcnt_n = '0;
          ones_n   = '0;
        end
      end
      SYNC: begin
        bitcnt_n = bitcnt + 3'd1;
        ones_n   = '0;
        if (bitcnt == 3'd7) begin
          state_n   = DATA;
          shreg_n   = hold_data;
          sh_last_n = hold_last;
          unload    = 1'b1;
        end
      end
      DATA: begin
        shreg_n  = shreg >> 1;
        bitcnt_n = bitcnt + 3'd1;
        ones_n   = shreg[0] ? ones + OW'(1) : '0;
        if (stuff_hit) begin
          state_n    = STUFF;
          pend_end_n = (bitcnt == 3'd7);
        end
      end
      STUFF: begin
        ones_n = '0;
        if (!pend_end) state_n = DATA;
      end
      EOP: begin
        eopcnt_n = eopcnt + EW'(1);
        if (eop_final) begin
          if (hold_full || take) begin
            state_n  = SYNC;
            bitcnt_n = '0;
            ones_n   = '0;
          end else begin
            state_n = IDLE;
          end
        end
      end
      default: state_n = IDLE;
    endcase

    if (byte_end) begin
      pend_end_n = 1'b0;
      if (sh_last) begin
        state_n    = EOP;
        eopcnt_n   = '0;
        underrun_n = 1'b0;
      end else if (hold_full) begin
        state_n   = DATA;
        shreg_n   = hold_data;
        sh_last_n = hold_last;
        bitcnt_n  = '0;
        unload    = 1'b1;
      end else begin
        state_n    = EOP;
        eopcnt_n   = '0;
        underrun_n = 1'b1;
      end
    end

    hold_data_n = take ? tx_data : hold_data;
    hold_last_n = take ? tx_last : hold_last;
    hold_full_n = take ? 1'b1 : (unload ? 1'b0 : hold_full);
  end

  always_comb begin
    tx_ready = ~hold_full;
    outb     = 1'b0;
    sending  = 1'b0;
    eop      = 1'b0;
    done     = 1'b0;
    err      = 1'b0;
    case (state)
      SYNC:  begin outb = SYNC_BYTE[bitcnt]; sending = 1'b1; end
      DATA:  begin outb = shreg[0];          sending = 1'b1; end
      STUFF: sending = 1'b1;
      EOP:   begin eop = 1'b1; done = eop_final && !underrun; end
      default: ;
    endcase
    err = byte_end && !sh_last && !hold_full;
  end

endmodule

// File: tb/tb_bit_serializer_tx.sv
// Scoreboard bench for bit_serializer_tx: drivers push expected per-cycle output frames,
// a negedge monitor pops and compares whenever the DUT shows activity.
module tb_bit_serializer_tx;

  logic       clk;
  logic       rst_L;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_last;
  logic       tx_ready;
  logic       outb, sending, eop, done, err;

  bit_serializer_tx #(.SYNC_BYTE(8'h80), .STUFF_RUN(6), .EOP_CYCLES(2)) dut (
    .clk(clk), .rst_L(rst_L), .tx_data(tx_data), .tx_valid(tx_valid), .tx_last(tx_last),
    .tx_ready(tx_ready), .outb(outb), .sending(sending), .eop(eop), .done(done), .err(err)
  );

  typedef struct packed {
    logic outb, sending, eop, done, err, last;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   checks = 0;
  int   fails  = 0;
  bit   in_pkt = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // bit string s: payload as transmitted, first character first
  task automatic push_pkt(input string s, input bit underrun);
    exp_t       e;
    logic [7:0] sb;
    sb = 8'h80;
    for (int i = 0; i < 8; i++) begin
      e = '0; e.sending = 1'b1; e.outb = sb[i];
      q.push_back(e);
    end
    for (int i = 0; i < s.len(); i++) begin
      e = '0; e.sending = 1'b1; e.outb = (s[i] == "1");
      e.err = underrun && (i == s.len() - 1);
      q.push_back(e);
    end
    for (int i = 0; i < 2; i++) begin
      e = '0; e.eop = 1'b1; e.done = !underrun && (i == 1); e.last = (i == 1);
      q.push_back(e);
    end
  endtask

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
    checks++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: actual=%b required=%b", name, act, req);
    end
  endtask

  // called #1 after a posedge; returns #1 after the accepting posedge
  task automatic send_byte(input logic [7:0] d, input logic l);
    int n = 0;
    tx_data = d; tx_last = l; tx_valid = 1'b1;
    while (!tx_ready && n < 200) begin
      @(posedge clk); #1; n++;
    end
    if (!tx_ready) begin
      checks++; fails++;
      $display("FAIL ready_timeout: actual tx_ready=0 required 1 within 200 cycles");
    end else begin
      @(posedge clk); #1;
    end
  endtask

  task automatic drain(input string name);
    int n = 0;
    while ((q.size() != 0 || in_pkt) && n < 300) begin
      @(posedge clk); n++;
    end
    @(posedge clk); #1;
    checks++;
    if (q.size() != 0 || in_pkt) begin
      fails++;
      $display("FAIL %s_drain: actual %0d frames pending required 0", name, q.size());
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (!rst_L) begin
        in_pkt = 0;
      end else if (sending || eop || done || err) begin
        checks++;
        if (q.size() == 0) begin
          fails++;
          $display("FAIL unexpected_output: actual {outb,sending,eop,done,err}=%b required idle",
                   {outb, sending, eop, done, err});
        end else begin
          mon_e = q.pop_front();
          if ({outb, sending, eop, done, err} !==
              {mon_e.outb, mon_e.sending, mon_e.eop, mon_e.done, mon_e.err}) begin
            fails++;
            $display("FAIL frame: actual {outb,sending,eop,done,err}=%b required %b at %0t",
                     {outb, sending, eop, done, err},
                     {mon_e.outb, mon_e.sending, mon_e.eop, mon_e.done, mon_e.err}, $time);
          end
          in_pkt = !mon_e.last;
        end
      end else if (in_pkt) begin
        checks++; fails++;
        $display("FAIL gap: actual idle cycle required continuous packet at %0t", $time);
        in_pkt = 0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: actual simulation still running required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_L = 1'b0; tx_valid = 1'b0; tx_data = '0; tx_last = 1'b0;
    #12;
    check("reset_outputs", {2'b0, outb, sending, eop, done, err, tx_ready}, 8'b0000_0001);
    #10 rst_L = 1'b1;
    @(posedge clk); #1;

    // 1: single byte, latency to first SYNC bit
    push_pkt("11000011", 1'b0);
    send_byte(8'hC3, 1'b1);
    tx_valid = 1'b0;
    check("latency_sync_start", {6'b0, sending, outb}, 8'b0000_0010);
    drain("t1");

    // 2: six ones force a stuffed zero
    push_pkt("111111011", 1'b0);
    send_byte(8'hFF, 1'b1);
    tx_valid = 1'b0;
    drain("t2");

    // 3: ones run crossing a byte boundary
    push_pkt("00001111110000000", 1'b0);
    send_byte(8'hF0, 1'b0);
    send_byte(8'h03, 1'b1);
    tx_valid = 1'b0;
    drain("t3");

    // 4: underrun
    push_pkt("10100101", 1'b1);
    send_byte(8'hA5, 1'b0);
    tx_valid = 1'b0;
    drain("t4");
    check("idle_ready_after_underrun", {7'b0, tx_ready}, 8'd1);

    // 5: three bytes streamed with tx_valid held
    push_pkt({"01001000", "00101100", "01101010"}, 1'b0);
    send_byte(8'h12, 1'b0);
    check("ready_low_when_full", {7'b0, tx_ready}, 8'd0);
    send_byte(8'h34, 1'b0);
    send_byte(8'h56, 1'b1);
    tx_valid = 1'b0;
    drain("t5");

    // 6: reset in the middle of DATA
    push_pkt("11000011", 1'b0);
    send_byte(8'hC3, 1'b1);
    tx_valid = 1'b0;
    repeat (11) @(posedge clk);
    #2;
    check("mid_data_before_reset", {7'b0, sending}, 8'd1);
    rst_L = 1'b0;
    q.delete();
    #1;
    check("abort_outputs", {2'b0, outb, sending, eop, done, err, tx_ready}, 8'b0000_0001);
    repeat (2) @(posedge clk);
    #7 rst_L = 1'b1;
    @(posedge clk); #1;
    check("abort_stays_idle", {2'b0, outb, sending, eop, done, err, tx_ready}, 8'b0000_0001);
    push_pkt("11000011", 1'b0);
    send_byte(8'hC3, 1'b1);
    tx_valid = 1'b0;
    drain("t6");

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
